// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its producers.
// FIFO command codes and the UART receiver state encoding.
package fifo_pkg;

   localparam logic [1:0] CMD_NONE = 2'd0;
   localparam logic [1:0] CMD_PUSH = 2'd1;
   localparam logic [1:0] CMD_POP  = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      PUSH,
      BREAK
   } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports: i_clk, i_reset (async, active-high), i_d (async in), o_q (synced).
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_push.sv
// UART receiver (8N1, LSB first) issuing each good byte as a FIFO PUSH.
// Ports: i_clk, i_reset (async, active-high), i_rx (serial, idle high),
//   i_full (drop byte when high); o_enable/o_cmd/o_data (FIFO command),
//   o_busy, o_frame_err, o_overrun, and o_parity_err when
//   UART_RX_PARITY_EN is defined (adds one even-parity bit per frame).
module uart_rx_push
   import fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int WIDTH        = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_rx,
   input  logic             i_full,
   output logic             o_enable,
   output logic [1:0]       o_cmd,
   output logic [WIDTH-1:0] o_data,
   output logic             o_busy,
   output logic             o_frame_err,
   output logic             o_overrun
`ifdef UART_RX_PARITY_EN
   ,
   output logic             o_parity_err
`endif
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(WIDTH + 1);

   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   logic rx_s;

   uart_rx_state_t state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       cmd_q, cmd_d;
   logic             en_q, en_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
   logic             perr_q, perr_d;
   logic             pbad_q, pbad_d;
`endif

   logic tick;

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   // Counter reaching zero marks the sample point of the current bit.
   assign tick = (cnt_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      cmd_d   = CMD_NONE;
      en_d    = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d  = 1'b0;
      pbad_d  = pbad_q;
`endif

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               cnt_d   = HALF_M1;
               state_d = START;
            end
         end

         START: begin
            if (tick) begin
               if (!rx_s) begin
                  cnt_d   = FULL_M1;
                  idx_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         DATA: begin
            if (tick) begin
               // LSB arrives first, so shift in from the top.
               shift_d = (shift_q >> 1)
                       | (WIDTH'(rx_s) << (WIDTH - 1));
               cnt_d   = FULL_M1;
               if (idx_q == LAST_BIT) begin
                  idx_d   = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick) begin
               // Even parity: data plus parity bit must xor to zero.
               pbad_d  = ^{shift_q, rx_s};
               cnt_d   = FULL_M1;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`endif

         STOP: begin
            if (tick) begin
               if (!rx_s) begin
                  ferr_d  = 1'b1;
                  state_d = BREAK;
`ifdef UART_RX_PARITY_EN
               end else if (pbad_q) begin
                  perr_d  = 1'b1;
                  state_d = IDLE;
`endif
               end else if (i_full) begin
                  ovr_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  en_d    = 1'b1;
                  cmd_d   = CMD_PUSH;
                  data_d  = shift_q;
                  state_d = PUSH;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         PUSH: begin
            state_d = IDLE;
         end

         // A line held low must go high before a new start is seen.
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         cmd_q   <= CMD_NONE;
         en_q    <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
         en_q    <= en_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         perr_q <= 1'b0;
         pbad_q <= 1'b0;
      end else begin
         perr_q <= perr_d;
         pbad_q <= pbad_d;
      end
   end

   assign o_parity_err = perr_q;
`endif

   assign o_enable    = en_q;
   assign o_cmd       = cmd_q;
   assign o_data      = data_q;
   assign o_busy      = (state_q != IDLE);
   assign o_frame_err = ferr_q;
   assign o_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_push.sv
// Randomized self-checking bench for uart_rx_push (CLKS_PER_BIT=4).
// Expected events are derived from frame contents and bit timing.
module tb_uart_rx_push;

   localparam int C = 4;
   localparam int H = C / 2;
   localparam int W = 8;
`ifdef UART_RX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   localparam int K_PUSH = 1;
   localparam int K_FERR = 2;
   localparam int K_OVR  = 3;
   localparam int K_PERR = 4;

   typedef struct {
      int cyc;
      int kind;
      int data;
      int cmd;
   } ev_t;

   logic         i_clk = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_rx = 1'b1;
   logic         i_full = 1'b0;
   logic         o_enable;
   logic [1:0]   o_cmd;
   logic [W-1:0] o_data;
   logic         o_busy;
   logic         o_frame_err;
   logic         o_overrun;
`ifdef UART_RX_PARITY_EN
   logic         o_parity_err;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int bad_cmd = 0;
   int last_push = 0;
   ev_t obs[$];
   ev_t exp_q[$];

   uart_rx_push #(
      .CLKS_PER_BIT (C),
      .WIDTH        (W)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx         (i_rx),
      .i_full       (i_full),
      .o_enable     (o_enable),
      .o_cmd        (o_cmd),
      .o_data       (o_data),
      .o_busy       (o_busy),
      .o_frame_err  (o_frame_err),
      .o_overrun    (o_overrun)
`ifdef UART_RX_PARITY_EN
      ,
      .o_parity_err (o_parity_err)
`endif
   );

   always #5 i_clk = ~i_clk;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic rec(input int kind);
      ev_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.data = int'(o_data);
      e.cmd  = int'(o_cmd);
      obs.push_back(e);
   endtask

   always @(negedge i_clk) begin
      if (!i_reset) begin
         if (o_enable) rec(K_PUSH);
         if (o_frame_err) rec(K_FERR);
         if (o_overrun) rec(K_OVR);
`ifdef UART_RX_PARITY_EN
         if (o_parity_err) rec(K_PERR);
`endif
         if (!o_enable && o_cmd != 2'd0) bad_cmd++;
      end
   end

   task automatic expect_ev(input int c, input int kind, input int d);
      ev_t e;
      e.cyc  = c;
      e.kind = kind;
      e.data = d;
      e.cmd  = (kind == K_PUSH) ? 1 : 0;
      exp_q.push_back(e);
   endtask

   // Caller is aligned 1 time unit after a rising edge.
   task automatic hold(input logic v, input int n);
      i_rx = v;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d,
                             input bit stop_ok,
                             input bit full,
                             input bit par_bad);
      int k;
      int t;
      k = cyc;
      hold(1'b0, C);
      for (int b = 0; b < W; b++) begin
         i_full = 1'($urandom_range(1));
         hold(d[b], C);
      end
      if (P == 1) hold((^d) ^ par_bad, C);
      i_full = full;
      // Stop sample: 2 sync cycles, half a bit, then W+1+P bit times.
      t = k + 2 + H + (W + 1 + P) * C + 1;
      if (!stop_ok) begin
         expect_ev(t, K_FERR, last_push);
      end else if (P == 1 && par_bad) begin
         expect_ev(t, K_PERR, last_push);
      end else if (full) begin
         expect_ev(t, K_OVR, last_push);
      end else begin
         expect_ev(t, K_PUSH, int'(d));
         last_push = int'(d);
      end
      hold(stop_ok, C);
   endtask

   initial begin
      int k;
      int n;
      logic [7:0] mid;
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      @(negedge i_clk);
      check("rst_enable", o_enable, 0);
      check("rst_cmd", o_cmd, 0);
      check("rst_data", o_data, 0);
      check("rst_busy", o_busy, 0);
      check("rst_ferr", o_frame_err, 0);
      check("rst_ovr", o_overrun, 0);
      @(posedge i_clk);
      #1;
      hold(1'b1, 4);

      send_frame(8'hA5, 1, 0, 0);
      hold(1'b1, 3);

      // Two-cycle glitch: start sample sees the line high again.
      k = cyc;
      hold(1'b0, 2);
      i_rx = 1'b1;
      @(negedge i_clk);
      check("glitch_busy_n", o_busy, 0);
      @(negedge i_clk);
      check("glitch_busy_n1", o_busy, 1);
      repeat (H) @(negedge i_clk);
      check("glitch_cyc", cyc, k + 2 + H + 1);
      check("glitch_busy_end", o_busy, 0);
      @(posedge i_clk);
      #1;
      hold(1'b1, 3);

      send_frame(8'h3C, 0, 0, 0);
      hold(1'b0, 20);
      hold(1'b1, 3);
      send_frame(8'h5A, 1, 0, 0);
      hold(1'b1, 2);

      send_frame(8'h7E, 1, 1, 0);
      hold(1'b1, 2);
      i_full = 1'b0;

      send_frame(8'h01, 1, 0, 0);
      send_frame(8'hFF, 1, 0, 0);
      hold(1'b1, 6);

      // Reset in the middle of the data bits of 0x55.
      mid = 8'h55;
      hold(1'b0, C);
      for (int b = 0; b < 3; b++) hold(mid[b], C);
      i_reset = 1'b1;
      i_rx = 1'b1;
      #1;
      check("mid_rst_busy", o_busy, 0);
      check("mid_rst_enable", o_enable, 0);
      check("mid_rst_cmd", o_cmd, 0);
      check("mid_rst_data", o_data, 0);
      check("mid_rst_ferr", o_frame_err, 0);
      check("mid_rst_ovr", o_overrun, 0);
      last_push = 0;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      hold(1'b1, 3);
      send_frame(8'h12, 1, 0, 0);
      hold(1'b1, 2);
`ifdef UART_RX_PARITY_EN
      send_frame(8'h12, 1, 0, 1);
      hold(1'b1, 2);
`endif

      for (int i = 0; i < 24; i++) begin
         logic [7:0] d;
         bit ok;
         bit fl;
         bit pb;
         d  = 8'($urandom);
         ok = ($urandom_range(7) != 0);
         fl = ($urandom_range(3) == 0);
         pb = (P == 1) && ($urandom_range(3) == 0);
         send_frame(d, ok, fl, pb);
         if (!ok) begin
            hold(1'b0, $urandom_range(20));
            hold(1'b1, 2 + $urandom_range(3));
         end else begin
            hold(1'b1, $urandom_range(3));
         end
      end
      i_full = 1'b0;
      hold(1'b1, 40);

      n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
      check("event_count", obs.size(), exp_q.size());
      for (int i = 0; i < n; i++) begin
         check($sformatf("ev%0d_kind", i), obs[i].kind, exp_q[i].kind);
         check($sformatf("ev%0d_cyc", i), obs[i].cyc, exp_q[i].cyc);
         check($sformatf("ev%0d_data", i), obs[i].data, exp_q[i].data);
         check($sformatf("ev%0d_cmd", i), obs[i].cmd, exp_q[i].cmd);
      end
      check("stray_cmd", bad_cmd, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
